inst_fetch: RTL and testbench

Instruction-fetch stage of the ToruMIPS pipeline. It owns the program counter, drives the instruction ROM request interface (`rom_ce_o` / `inst_addr_o`), captures returned words into a 2-entry buffer, and hands `{pc, inst}` pairs to the decode stage over a valid/ready handshake. It supports redirects (branch/jump) that flush all fetched and in-flight words.

---
 rtl/inst_fetch.sv | 88 ++++++++
 tb/tb_inst_fetch.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, issues ROM requests, buffers returned
// words in a 2-entry FIFO and hands {pc, inst} pairs to decode over valid/ready.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce_o,
  output logic [31:0] inst_addr_o,
  input  logic [31:0] inst_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
);

  logic [31:0] pc;
  logic        inflight;
  logic [31:0] inflight_pc;

  logic [31:0] fifo_pc   [2];
  logic [31:0] fifo_inst [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;

  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  occupancy;

  assign pop = id_valid_o & id_ready_i;

  // Slots committed after this edge; a new request only fits if fewer than two
  // words would remain buffered or outstanding, so the FIFO can never overflow.
  assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = !rst && !redirect_i && (occupancy < 3'd2);
  assign push      = inflight && !redirect_i;

  assign rom_ce_o    = issue;
  assign inst_addr_o = pc;

  assign id_valid_o = (count != 2'd0);
  assign id_pc_o    = id_valid_o ? fifo_pc[rd_ptr]   : 32'h0;
  assign id_inst_o  = id_valid_o ? fifo_inst[rd_ptr] : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
      count       <= 2'd0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
    end else if (redirect_i) begin
      // Flush drops buffered words, the outstanding response and any pop.
      pc       <= {redirect_pc_i[31:2], 2'b00};
      inflight <= 1'b0;
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + 32'd4;
      end
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Payload storage needs no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_pc[wr_ptr]   <= inflight_pc;
      fifo_inst[wr_ptr] <= inst_i;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: ROM[word i] = i + 0x100, expectations per cycle
// packed as {rom_ce, inst_addr, id_valid, id_pc, id_inst}.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        rom_ce_o;
  logic [31:0] inst_addr_o;
  logic [31:0] inst_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  int n_cmp;
  int n_err;

  logic        last_ce;
  logic [31:0] last_addr;

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .rom_ce_o     (rom_ce_o),
    .inst_addr_o  (inst_addr_o),
    .inst_i       (inst_i),
    .id_valid_o   (id_valid_o),
    .id_ready_i   (id_ready_i),
    .id_pc_o      (id_pc_o),
    .id_inst_o    (id_inst_o),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (!rst) begin
      n_cmp++;
      if (dut.count > 2'd2) begin
        $display("FAIL count_bound: got %0d want <=2", dut.count);
        n_err++;
      end
    end
  end

  function automatic logic [97:0] ev(input logic ce, input logic [31:0] a, input logic v,
                                     input logic [31:0] p, input logic [31:0] i);
    return {ce, a, v, p, i};
  endfunction

  function automatic logic [97:0] observed();
    return {rom_ce_o, inst_addr_o, id_valid_o, id_pc_o, id_inst_o};
  endfunction

  // One cycle: ROM answers last cycle's request, inputs change, outputs settle.
  task automatic drive(input logic r, input logic rdy, input logic rdr, input logic [31:0] rpc);
    @(negedge clk);
    inst_i        = last_ce ? ((last_addr >> 2) + 32'h100) : 32'hDEAD_BEEF;
    rst           = r;
    id_ready_i    = rdy;
    redirect_i    = rdr;
    redirect_pc_i = rpc;
    #1;
    last_ce   = rom_ce_o;
    last_addr = inst_addr_o;
  endtask

  task automatic test_reset();
    logic [97:0] act;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      act = observed();
      n_cmp++;
      if (act !== ev(1'b0, 32'h0, 1'b0, 32'h0, 32'h0)) begin
        $display("FAIL reset[%0d]: got %h want %h", i, act, ev(1'b0, 32'h0, 1'b0, 32'h0, 32'h0));
        n_err++;
      end
    end
  endtask

  task automatic test_stream();
    logic [97:0] act;
    logic [97:0] exp;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      if (k >= 2)
        exp = ev(1'b1, 32'(4 * k), 1'b1, 32'(4 * (k - 2)), 32'(32'h100 + k - 2));
      else
        exp = ev(1'b1, 32'(4 * k), 1'b0, 32'h0, 32'h0);
      act = observed();
      n_cmp++;
      if (act !== exp) begin
        $display("FAIL stream[%0d]: got %h want %h", k, act, exp);
        n_err++;
      end
    end
  endtask

  task automatic test_stall();
    logic [97:0] act;
    logic [97:0] ex [8];
    ex = '{ev(1'b0, 32'd16, 1'b1, 32'd8, 32'h102), ev(1'b0, 32'd16, 1'b1, 32'd8, 32'h102),
           ev(1'b0, 32'd16, 1'b1, 32'd8, 32'h102), ev(1'b0, 32'd16, 1'b1, 32'd8, 32'h102),
           ev(1'b1, 32'd16, 1'b1, 32'd8, 32'h102), ev(1'b1, 32'd20, 1'b1, 32'd12, 32'h103),
           ev(1'b1, 32'd24, 1'b1, 32'd16, 32'h104), ev(1'b1, 32'd28, 1'b1, 32'd20, 32'h105)};
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, (i >= 4), 1'b0, 32'h0);
      act = observed();
      n_cmp++;
      if (act !== ex[i]) begin
        $display("FAIL stall[%0d]: got %h want %h", i, act, ex[i]);
        n_err++;
      end
    end
  endtask

  task automatic test_redirect();
    logic [97:0] act;
    logic [97:0] ex [5];
    ex = '{ev(1'b0, 32'd32, 1'b1, 32'd24, 32'h106), ev(1'b1, 32'h40, 1'b0, 32'h0, 32'h0),
           ev(1'b1, 32'h44, 1'b0, 32'h0, 32'h0), ev(1'b1, 32'h48, 1'b1, 32'h40, 32'h110),
           ev(1'b1, 32'h4C, 1'b1, 32'h44, 32'h111)};
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, (i != 0), (i == 0), 32'h0000_0043);
      act = observed();
      n_cmp++;
      if (act !== ex[i]) begin
        $display("FAIL redirect[%0d]: got %h want %h", i, act, ex[i]);
        n_err++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [97:0] act;
    logic [97:0] ex [6];
    logic [31:0] tgt [6];
    ex = '{ev(1'b0, 32'h50, 1'b1, 32'h48, 32'h112), ev(1'b0, 32'h200, 1'b0, 32'h0, 32'h0),
           ev(1'b1, 32'h80, 1'b0, 32'h0, 32'h0), ev(1'b1, 32'h84, 1'b0, 32'h0, 32'h0),
           ev(1'b1, 32'h88, 1'b1, 32'h80, 32'h120), ev(1'b1, 32'h8C, 1'b1, 32'h84, 32'h121)};
    tgt = '{32'h200, 32'h80, 32'h0, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, (i < 2), tgt[i]);
      act = observed();
      n_cmp++;
      if (act !== ex[i]) begin
        $display("FAIL back_to_back[%0d]: got %h want %h", i, act, ex[i]);
        n_err++;
      end
    end
  endtask

  task automatic test_wrap();
    logic [97:0] act;
    logic [97:0] ex [6];
    ex = '{ev(1'b0, 32'h90, 1'b1, 32'h88, 32'h122),
           ev(1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0, 32'h0),
           ev(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0),
           ev(1'b1, 32'h0, 1'b1, 32'hFFFF_FFF8, 32'h4000_00FE),
           ev(1'b1, 32'h4, 1'b1, 32'hFFFF_FFFC, 32'h4000_00FF),
           ev(1'b1, 32'h8, 1'b1, 32'h0, 32'h100)};
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, (i == 0), 32'hFFFF_FFF8);
      act = observed();
      n_cmp++;
      if (act !== ex[i]) begin
        $display("FAIL wrap[%0d]: got %h want %h", i, act, ex[i]);
        n_err++;
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [97:0] act;
    logic [97:0] ex [5];
    ex = '{ev(1'b0, 32'd12, 1'b1, 32'd4, 32'h101), ev(1'b1, 32'd0, 1'b0, 32'h0, 32'h0),
           ev(1'b1, 32'd4, 1'b0, 32'h0, 32'h0), ev(1'b1, 32'd8, 1'b1, 32'd0, 32'h100),
           ev(1'b1, 32'd12, 1'b1, 32'd4, 32'h101)};
    for (int i = 0; i < 5; i++) begin
      drive((i == 0), 1'b1, 1'b0, 32'h0);
      act = observed();
      n_cmp++;
      if (act !== ex[i]) begin
        $display("FAIL mid_reset[%0d]: got %h want %h", i, act, ex[i]);
        n_err++;
      end
    end
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    last_ce       = 1'b0;
    last_addr     = 32'h0;
    rst           = 1'b1;
    id_ready_i    = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    inst_i        = 32'h0;

    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_mid_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
